// File: rtl/alu_control_sequencer.sv
// Hardwired control-step generator for register-register ALU instructions.
// A Moore FSM walks fetch (T0-T2) and operand/execute/writeback (T3-T6) steps.
module alu_control_sequencer #(
  parameter logic [4:0] OP_MUL = 5'b01111,
  parameter logic [4:0] OP_DIV = 5'b10000,
  parameter logic [4:0] OP_NEG = 5'b10001,
  parameter logic [4:0] OP_NOT = 5'b10010,
  parameter logic [4:0] OP_MAX = 5'b10010
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MARin,
  output logic        incPC,
  output logic        read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  opcode,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StDone, StIll
  } state_t;

  state_t state_q, state_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_wide, is_unary, is_illegal;
  logic       unused_ir;

  assign op         = ir[31:27];
  assign ra         = ir[26:23];
  assign rb         = ir[22:19];
  assign rc         = ir[18:15];
  assign is_wide    = (op == OP_MUL) || (op == OP_DIV);
  assign is_unary   = (op == OP_NEG) || (op == OP_NOT);
  assign is_illegal = (op > OP_MAX);
  assign unused_ir  = ^ir[14:0];

  always_ff @(posedge clock) begin
    if (clear) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3:    state_d = is_illegal ? StIll : StT4;
      StT4:    state_d = StT5;
      StT5:    state_d = is_wide ? StT6 : StDone;
      StT6:    state_d = StDone;
      StDone:  state_d = run ? StT0 : StIdle;
      StIll:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The IR is loaded at the end of T2, so every ir-derived output is T3 or later.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    incPC    = 1'b0;
    read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rin      = 16'h0000;
    Rout     = 16'h0000;
    opcode   = 5'b00000;
    done     = 1'b0;
    illegal  = 1'b0;
    unique case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        incPC = 1'b1;
      end
      StT1: begin
        read  = 1'b1;
        MDRin = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        // Unary ops and illegal opcodes take a bubble here.
        if (!is_unary && !is_illegal) begin
          Rout = 16'h0001 << rb;
          Yin  = 1'b1;
        end
      end
      StT4: begin
        Rout   = 16'h0001 << (is_unary ? rb : rc);
        opcode = op;
        Zin    = 1'b1;
      end
      StT5: begin
        ZLowOut = 1'b1;
        if (is_wide) LOin = 1'b1;
        else         Rin  = 16'h0001 << ra;
      end
      StT6: begin
        ZHighOut = 1'b1;
        HIin     = 1'b1;
      end
      StDone:  done    = 1'b1;
      StIll:   illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: expected control vectors are queued
// per instruction and popped one per clock as the sequencer steps.
module tb_alu_control_sequencer;

  typedef struct packed {
    logic        pc_out, mar_in, inc_pc, rd, mdr_in, mdr_out, ir_in, y_in, z_in;
    logic        zlo_out, zhi_out, lo_in, hi_in;
    logic [15:0] rin, rout;
    logic [4:0]  op;
    logic        done, ill;
  } ctl_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        PCout, MARin, incPC, read, MDRin, MDRout, IRin, Yin, Zin;
  logic        ZLowOut, ZHighOut, LOin, HIin, done, illegal;
  logic [15:0] Rin, Rout;
  logic [4:0]  opcode;

  ctl_t obs;
  ctl_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  alu_control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
    .PCout(PCout), .MARin(MARin), .incPC(incPC), .read(read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut),
    .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin), .Rin(Rin), .Rout(Rout),
    .opcode(opcode), .done(done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign obs = '{pc_out: PCout, mar_in: MARin, inc_pc: incPC, rd: read, mdr_in: MDRin,
                 mdr_out: MDRout, ir_in: IRin, y_in: Yin, z_in: Zin, zlo_out: ZLowOut,
                 zhi_out: ZHighOut, lo_in: LOin, hi_in: HIin, rin: Rin, rout: Rout,
                 op: opcode, done: done, ill: illegal};

  function automatic logic [4:0] ir_word_op(input logic [31:0] i);
    return i[31:27];
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'h0};
  endfunction

  // Expected step sequence of one instruction, derived from the control-step table.
  task automatic push_instr(input logic [31:0] i, output int n);
    ctl_t c;
    logic [4:0] op;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    bit wide, unary;
    op    = ir_word_op(i);
    ra_oh = 16'h0001 << i[26:23];
    rb_oh = 16'h0001 << i[22:19];
    rc_oh = 16'h0001 << i[18:15];
    wide  = (op == 5'b01111) || (op == 5'b10000);
    unary = (op == 5'b10001) || (op == 5'b10010);
    n = 0;
    c = '0; c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; exp_q.push_back(c); n++;
    c = '0; c.rd = 1; c.mdr_in = 1; exp_q.push_back(c); n++;
    c = '0; c.mdr_out = 1; c.ir_in = 1; exp_q.push_back(c); n++;
    if (op > 5'b10010) begin
      c = '0; exp_q.push_back(c); n++;
      c = '0; c.ill = 1; exp_q.push_back(c); n++;
      return;
    end
    c = '0;
    if (!unary) begin c.rout = rb_oh; c.y_in = 1; end
    exp_q.push_back(c); n++;
    c = '0; c.rout = unary ? rb_oh : rc_oh; c.op = op; c.z_in = 1; exp_q.push_back(c); n++;
    c = '0; c.zlo_out = 1;
    if (wide) c.lo_in = 1; else c.rin = ra_oh;
    exp_q.push_back(c); n++;
    if (wide) begin
      c = '0; c.zhi_out = 1; c.hi_in = 1; exp_q.push_back(c); n++;
    end
    c = '0; c.done = 1; exp_q.push_back(c); n++;
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(ctl_t'('0));
  endtask

  task automatic step(input string tag, input int n);
    ctl_t e;
    int drv;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL %s queue: observed empty scoreboard, expected a queued step", tag);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
          n_fail++;
          $error("FAIL %s step%0d: observed %h expected %h", tag, k, obs, e);
        end
      end
      drv = int'(PCout) + int'(MDRout) + int'(|Rout) + int'(ZLowOut) + int'(ZHighOut);
      n_cmp++;
      assert ((drv <= 1) && $onehot0(Rin) && $onehot0(Rout)) else begin
        n_fail++;
        $error("FAIL %s bus step%0d: observed drivers=%0d Rin=%h Rout=%h expected <=1 one-hot",
               tag, k, drv, Rin, Rout);
      end
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] i);
    int n;
    ir  = i;
    run = 1'b1;
    push_instr(i, n);
    step(tag, 1);
    run = 1'b0;
    step(tag, n - 1);
    push_idle(1);
    step({tag, "_idle"}, 1);
  endtask

  initial begin
    int n;
    logic [31:0] prog [3];

    push_idle(2);
    step("reset", 2);
    clear = 1'b0;
    push_idle(2);
    step("idle", 2);

    run_one("add", 32'h1A1B8000);
    run_one("shr", 32'h4A1B8000);
    run_one("mul", mk_ir(5'b01111, 4'd0, 4'd3, 4'd7));
    run_one("div", mk_ir(5'b10000, 4'd9, 4'd15, 4'd1));
    run_one("neg", mk_ir(5'b10001, 4'd2, 4'd5, 4'd0));
    run_one("not_max", mk_ir(5'b10010, 4'd15, 4'd14, 4'd13));
    run_one("same_reg", mk_ir(5'b00101, 4'd6, 4'd6, 4'd6));
    run_one("ill_1f", mk_ir(5'b11111, 4'd4, 4'd3, 4'd7));
    run_one("ill_13", mk_ir(5'b10011, 4'd1, 4'd2, 4'd3));

    // clear while the sequencer sits in T4
    ir  = 32'h1A1B8000;
    run = 1'b1;
    push_instr(ir, n);
    step("clr", 1);
    run = 1'b0;
    step("clr", 4);
    exp_q.delete();
    clear = 1'b1;
    push_idle(1);
    step("clr_t4", 1);
    clear = 1'b0;
    push_idle(1);
    step("clr_idle", 1);
    run_one("clr_restart", 32'h1A1B8000);

    // run held high: DONE flows straight into T0
    prog[0] = 32'h1A1B8000;
    prog[1] = mk_ir(5'b01111, 4'd0, 4'd3, 4'd7);
    prog[2] = mk_ir(5'b10010, 4'd8, 4'd11, 4'd0);
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ir = prog[k];
      push_instr(prog[k], n);
      if (k == 2) begin
        step("burst", n - 1);
        run = 1'b0;
        step("burst", 1);
      end else begin
        step("burst", n);
      end
    end
    push_idle(2);
    step("burst_idle", 2);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL leftover: observed %0d queued steps expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
